avalon_mm_sample_reader: RTL

//  Avalon-MM read master: the initiator for the 32-bit on-chip memory slaves in the

---
 rtl/avalon_mm_sample_reader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/avalon_mm_sample_reader.sv
// Avalon-MM burstless read master: fetches a block of words with pipelined reads
// and streams them out through a small first-word-fall-through FIFO.

module avalon_mm_sample_reader_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full FIFO can still take a word when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module avalon_mm_sample_reader #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  input  logic              m_waitrequest,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_readdatavalid,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t            state, state_nxt;
  logic [LEN_W-1:0]  remaining;
  logic [CNT_W-1:0]  outstanding, fifo_count;
  logic [CNT_W:0]    credit_used;
  logic              has_credit, accept, push, pop, fifo_empty;
  logic              start_run, last_accept, final_pop, done_nxt;

  // Every in-flight read owns a FIFO slot, so the FIFO can never overflow.
  assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
  assign has_credit  = credit_used < (CNT_W + 1)'(FIFO_DEPTH);

  assign m_read      = (state == S_ISSUE) & has_credit;
  assign accept      = m_read & ~m_waitrequest;
  assign last_accept = accept & (remaining == LEN_W'(1));
  // Read data with nothing outstanding is a slave protocol error and is dropped.
  assign push        = m_readdatavalid & (outstanding != '0);
  assign pop         = st_valid & st_ready;
  assign st_valid    = ~fifo_empty;
  assign busy        = (state != S_IDLE);
  assign start_run   = (state == S_IDLE) & start & (length != '0);
  assign final_pop   = (state == S_DRAIN) & (outstanding == '0) &
                       ((fifo_count == '0) | ((fifo_count == CNT_W'(1)) & pop));

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (length != '0) state_nxt = S_ISSUE;
          else              done_nxt  = 1'b1;
        end
      end
      S_ISSUE: begin
        if (last_accept) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (final_pop) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  // Address and count only move on an accepted read, so a stalled request holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_address <= '0;
      remaining <= '0;
    end else if (start_run) begin
      m_address <= base_addr;
      remaining <= length;
    end else if (accept) begin
      m_address <= m_address + ADDR_W'(1);
      remaining <= remaining - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
    end else begin
      case ({accept, push})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  avalon_mm_sample_reader_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (m_readdata),
    .pop     (pop),
    .rdata   (st_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );
endmodule
